// File: rtl/led_pkg.sv
// Shared types and default constants for the three-channel LED fader.
package led_pkg;

  localparam int DEF_PWM_BITS    = 8;
  localparam int DEF_STEP_CYCLES = 1000;
  localparam int NUM_CH          = 3;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    RAMP_UP   = 2'd1,
    ON        = 2'd2,
    RAMP_DOWN = 2'd3
  } fade_state_t;

endpackage

// File: rtl/led_fader_if.sv
// Request/drive bundle between the LED blinker, the fader and the LED pins.
interface led_fader_if import led_pkg::*; #(
  parameter int PWM_BITS = DEF_PWM_BITS
) ();

  // No valid/ready handshake: every signal is level-sampled on each rising clk
  // edge; led_req is a continuous per-channel request, acted on every cycle.
  logic                         enable;
  logic [NUM_CH-1:0]            led_req;
  logic [NUM_CH-1:0]            led_pwm;
  logic [NUM_CH-1:0]            busy;
  logic [NUM_CH*PWM_BITS-1:0]   dbg_level;
  logic [NUM_CH*2-1:0]          dbg_state;

  modport master (
    output enable, led_req,
    input  led_pwm, busy, dbg_level, dbg_state
  );

  modport slave (
    input  enable, led_req,
    output led_pwm, busy, dbg_level, dbg_state
  );

endinterface

// File: rtl/led_fader_ch.sv
// One fader channel: fade FSM, saturating brightness level and registered PWM pin.
module led_fader_ch import led_pkg::*; #(
  parameter int PWM_BITS = DEF_PWM_BITS
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                i_enable,
  input  logic                i_req,
  input  logic                i_tick,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  output logic                o_pwm,
  output logic                o_busy,
  output logic [PWM_BITS-1:0] o_level,
  output fade_state_t         o_state
);

  localparam logic [PWM_BITS-1:0] MAX_LEVEL = '1;
  localparam logic [PWM_BITS-1:0] ONE_LEVEL = PWM_BITS'(1);

  fade_state_t         r_state;
  fade_state_t         w_state_nxt;
  logic [PWM_BITS-1:0] r_level;
  logic [PWM_BITS-1:0] w_level_nxt;
  logic                r_pwm;
  logic                w_pwm_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= OFF;
      r_level <= '0;
      r_pwm   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
      r_pwm   <= w_pwm_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    // In bypass the pin follows the request directly so it is correct one cycle later.
    w_pwm_nxt   = i_enable ? (i_pwm_cnt < r_level) : i_req;

    if (!i_enable) begin
      w_state_nxt = i_req ? ON : OFF;
      w_level_nxt = i_req ? MAX_LEVEL : '0;
    end else begin
      unique case (r_state)
        OFF: begin
          if (i_req) w_state_nxt = RAMP_UP;
        end
        RAMP_UP: begin
          if (!i_req) begin
            w_state_nxt = RAMP_DOWN;
          end else if (i_tick) begin
            if (r_level != MAX_LEVEL) w_level_nxt = r_level + ONE_LEVEL;
            if (r_level >= MAX_LEVEL - ONE_LEVEL) w_state_nxt = ON;
          end
        end
        ON: begin
          if (!i_req) w_state_nxt = RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (i_req) begin
            w_state_nxt = RAMP_UP;
          end else if (i_tick) begin
            if (r_level != '0) w_level_nxt = r_level - ONE_LEVEL;
            if (r_level <= ONE_LEVEL) w_state_nxt = OFF;
          end
        end
        default: begin
          w_state_nxt = OFF;
          w_level_nxt = '0;
        end
      endcase
    end
  end

  assign o_pwm   = r_pwm;
  assign o_busy  = (r_state == RAMP_UP) || (r_state == RAMP_DOWN);
  assign o_level = r_level;
  assign o_state = r_state;

endmodule

// File: rtl/led_fader.sv
// Three-channel LED fader: shared step prescaler and PWM counter feeding three channels.
module led_fader import led_pkg::*; #(
  parameter int PWM_BITS    = DEF_PWM_BITS,
  parameter int STEP_CYCLES = DEF_STEP_CYCLES
) (
  input  logic        clk,
  input  logic        resetn,
  led_fader_if.slave  bus
);

  localparam int                  PS_W     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(STEP_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((2 ** PWM_BITS) - 2);

  logic [PS_W-1:0]                  r_ps_cnt;
  logic                             w_tick;
  logic [PWM_BITS-1:0]              r_pwm_cnt;
  logic [NUM_CH-1:0]                w_pwm;
  logic [NUM_CH-1:0]                w_busy;
  logic [NUM_CH-1:0][PWM_BITS-1:0]  w_level;
  fade_state_t                      w_state [NUM_CH];

  assign w_tick = (r_ps_cnt == PS_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ps_cnt <= '0;
    end else if (w_tick) begin
      r_ps_cnt <= '0;
    end else begin
      r_ps_cnt <= r_ps_cnt + 1'b1;
    end
  end

  // Period is MAX_LEVEL cycles so that a full-scale level compares high every cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pwm_cnt <= '0;
    end else if (r_pwm_cnt == PWM_LAST) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    led_fader_ch #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .clk       (clk),
      .resetn    (resetn),
      .i_enable  (bus.enable),
      .i_req     (bus.led_req[g]),
      .i_tick    (w_tick),
      .i_pwm_cnt (r_pwm_cnt),
      .o_pwm     (w_pwm[g]),
      .o_busy    (w_busy[g]),
      .o_level   (w_level[g]),
      .o_state   (w_state[g])
    );
  end

  assign bus.led_pwm   = w_pwm;
  assign bus.busy      = w_busy;
  assign bus.dbg_level = w_level;
  assign bus.dbg_state = {w_state[2], w_state[1], w_state[0]};

endmodule

// File: tb/tb_led_fader.sv
// Bench for led_fader at PWM_BITS=4, STEP_CYCLES=4 with a cycle model feeding an expected queue.
module tb_led_fader;
  import led_pkg::*;

  localparam int PWM_BITS = 4;
  localparam int STEP     = 4;
  localparam int MAXL     = 15;

  logic clk = 1'b0;
  logic resetn;

  led_fader_if #(.PWM_BITS(PWM_BITS)) bus ();

  led_fader #(
    .PWM_BITS    (PWM_BITS),
    .STEP_CYCLES (STEP)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: codes 0 OFF, 1 RAMP_UP, 2 ON, 3 RAMP_DOWN
  int m_ps, m_pc;
  int m_st [3];
  int m_lv [3];
  logic [23:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ps = 0;
    m_pc = 0;
    for (int c = 0; c < 3; c++) begin
      m_st[c] = 0;
      m_lv[c] = 0;
    end
    exp_q.delete();
  endfunction

  function automatic void model_step(input logic en, input logic [2:0] req);
    bit tk;
    int st [3];
    int lv [3];
    logic [2:0] pw, bz;
    tk = (m_ps == STEP - 1);
    for (int c = 0; c < 3; c++) begin
      st[c] = m_st[c];
      lv[c] = m_lv[c];
      pw[c] = en ? (m_pc < m_lv[c]) : req[c];
      if (!en) begin
        st[c] = req[c] ? 2 : 0;
        lv[c] = req[c] ? MAXL : 0;
      end else if (m_st[c] == 0) begin
        if (req[c]) st[c] = 1;
      end else if (m_st[c] == 2) begin
        if (!req[c]) st[c] = 3;
      end else if (req[c] != (m_st[c] == 1)) begin
        st[c] = (m_st[c] == 1) ? 3 : 1;
      end else if (tk) begin
        if (m_st[c] == 1) begin
          lv[c] = (m_lv[c] + 1 > MAXL) ? MAXL : m_lv[c] + 1;
          if (lv[c] == MAXL) st[c] = 2;
        end else begin
          lv[c] = (m_lv[c] - 1 < 0) ? 0 : m_lv[c] - 1;
          if (lv[c] == 0) st[c] = 0;
        end
      end
      bz[c] = (st[c] == 1) || (st[c] == 3);
    end
    for (int c = 0; c < 3; c++) begin
      m_st[c] = st[c];
      m_lv[c] = lv[c];
    end
    m_ps = (m_ps + 1) % STEP;
    m_pc = (m_pc + 1) % MAXL;
    exp_q.push_back({2'(st[2]), 2'(st[1]), 2'(st[0]),
                     4'(lv[2]), 4'(lv[1]), 4'(lv[0]), bz, pw});
  endfunction

  // Called at a negedge with inputs already driven; compares after the next edge.
  task automatic cycle();
    logic [23:0] e;
    model_step(bus.enable, bus.led_req);
    @(negedge clk);
    e = exp_q.pop_front();
    check("pwm",   32'(bus.led_pwm),   32'(e[2:0]));
    check("busy",  32'(bus.busy),      32'(e[5:3]));
    check("level", 32'(bus.dbg_level), 32'(e[17:6]));
    check("state", 32'(bus.dbg_state), 32'(e[23:18]));
  endtask

  initial begin
    int n;
    int cnt;
    bus.enable  = 1'b1;
    bus.led_req = 3'b000;
    resetn      = 1'b1;
    #1 resetn   = 1'b0;
    #1;
    check("rst_pwm",   32'(bus.led_pwm),   32'(0));
    check("rst_busy",  32'(bus.busy),      32'(0));
    check("rst_level", 32'(bus.dbg_level), 32'(0));
    check("rst_state", 32'(bus.dbg_state), 32'(0));
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    model_reset();

    // ramp up channel 0
    bus.led_req = 3'b001;
    cycle();
    check("ramp_start_busy", 32'(bus.busy), 32'(3'b001));
    n = 1;
    while (bus.busy[0] && n < 200) begin
      cycle();
      n++;
    end
    check("ramp_up_done", 32'(bus.busy[0]), 32'(0));
    check("ramp_up_len_ok", 32'(n >= 57 && n <= 63), 32'(1));
    check("ramp_up_level", 32'(bus.dbg_level[3:0]), 32'(MAXL));
    cycle();
    cnt = 0;
    repeat (20) begin
      cycle();
      if (bus.led_pwm[0]) cnt++;
    end
    check("full_on_duty", 32'(cnt), 32'(20));

    // back to OFF through bypass, then reversal at level 7 on a tick cycle
    bus.enable  = 1'b0;
    bus.led_req = 3'b000;
    cycle();
    bus.enable  = 1'b1;
    bus.led_req = 3'b001;
    n = 0;
    while (!(m_lv[0] == 7 && m_ps == STEP - 1) && n < 200) begin
      cycle();
      n++;
    end
    check("reach_l7", 32'(bus.dbg_level[3:0]), 32'(7));
    bus.led_req = 3'b000;
    cycle();
    check("rev_hold_level", 32'(bus.dbg_level[3:0]), 32'(7));
    check("rev_state", 32'(bus.dbg_state[1:0]), 32'(RAMP_DOWN));
    repeat (4) cycle();
    check("rev_first_step", 32'(bus.dbg_level[3:0]), 32'(6));
    n = 4;
    while (bus.busy[0] && n < 200) begin
      cycle();
      n++;
    end
    check("rev_len", 32'(n), 32'(28));
    check("rev_off_state", 32'(bus.dbg_state[1:0]), 32'(OFF));
    check("rev_off_level", 32'(bus.dbg_level[3:0]), 32'(0));

    // zero level never drives the pin
    cnt = 0;
    repeat (30) begin
      cycle();
      if (bus.led_pwm[0]) cnt++;
    end
    check("zero_duty", 32'(cnt), 32'(0));

    // hold level 5 by reversing on every tick, then measure duty
    bus.led_req = 3'b001;
    n = 0;
    while (m_lv[0] != 5 && n < 200) begin
      cycle();
      n++;
    end
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (m_ps == STEP - 1) bus.led_req = {bus.led_req[2:1], ~bus.led_req[0]};
      cycle();
      if (i > 0 && bus.led_pwm[0]) cnt++;
    end
    check("duty5", 32'(cnt), 32'(5));
    check("duty5_level", 32'(bus.dbg_level[3:0]), 32'(5));

    // bypass
    bus.enable  = 1'b0;
    bus.led_req = 3'b101;
    cycle();
    check("byp_pwm", 32'(bus.led_pwm), 32'(3'b101));
    check("byp_busy", 32'(bus.busy), 32'(0));
    cnt = 0;
    repeat (10) begin
      cycle();
      if (bus.led_pwm == 3'b101 && bus.busy == 3'b000) cnt++;
    end
    check("byp_steady", 32'(cnt), 32'(10));
    bus.enable = 1'b1;
    cycle();
    check("reen_no_ramp", 32'(bus.busy), 32'(0));
    bus.led_req = 3'b000;
    cycle();
    check("reen_down_busy", 32'(bus.busy), 32'(3'b101));
    n = 1;
    while (bus.busy != 3'b000 && n < 200) begin
      cycle();
      n++;
    end
    check("reen_down_len_ok", 32'(n >= 57 && n <= 63), 32'(1));

    // all three channels in parallel
    bus.led_req = 3'b111;
    cycle();
    check("par_busy", 32'(bus.busy), 32'(3'b111));
    n = 0;
    while (bus.busy == 3'b111 && n < 200) begin
      cycle();
      n++;
    end
    check("par_drop_together", 32'(bus.busy), 32'(0));
    check("par_levels", 32'(bus.dbg_level), 32'(12'hfff));

    // asynchronous reset in the middle of a ramp
    bus.led_req = 3'b000;
    repeat (20) cycle();
    #2 resetn = 1'b0;
    #1;
    check("async_rst_pwm",   32'(bus.led_pwm),   32'(0));
    check("async_rst_busy",  32'(bus.busy),      32'(0));
    check("async_rst_level", 32'(bus.dbg_level), 32'(0));
    repeat (2) @(negedge clk);
    bus.led_req = 3'b111;
    resetn = 1'b1;
    model_reset();
    cycle();
    check("post_rst_rerap", 32'(bus.busy), 32'(3'b111));
    repeat (30) cycle();

    // random requests and occasional bypass
    repeat (500) begin
      if ($urandom_range(0, 15) == 0) bus.led_req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 59) == 0) bus.enable = ~bus.enable;
      cycle();
    end
    bus.enable = 1'b1;
    cycle();

    check("sb_drain", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
